// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding, default width, counter sizing.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Ceiling log2 with a floor of 1 so a counter always has at least one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder chained from full_adder cells.
module ripple_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             cin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             cout,
  output logic [WIDTH-1:0] s
);

  // Each stage owns its carry wires so the chain is not one self-referencing vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic ci;
    logic co;

    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_rest
      assign ci = g_bit[i-1].co;
    end

    full_adder u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (ci),
      .s  (s[i]),
      .co (co)
    );
  end

  assign cout = g_bit[WIDTH-1].co;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one multiplier bit per cycle through a shared ripple adder.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = clog2_min1(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    product_q, product_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;

  assign addend = mplr_q[0] ? mcand_q : '0;

  ripple_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .cin  (1'b0),
    .x    (acc_q),
    .y    (addend),
    .cout (carry),
    .s    (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  // Next-state, datapath update and registered handshake flags.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          mplr_d  = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Shift {carry,sum,mplr} right by one: carry lands in acc MSB, sum LSB enters mplr.
        acc_d  = {carry, sum[WIDTH-1:1]};
        mplr_d = {sum[0], mplr_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          product_d = {acc_d, mplr_d};
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: driver pushes a*b on accept, negedge monitor pops on done.
module tb_shift_add_multiplier;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 2 * W;

  typedef struct {
    logic [PW-1:0] prod;
    int            cyc;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ready;
  logic          done;
  logic [PW-1:0] product;

  exp_t          exp_q[$];
  logic [PW-1:0] model_prod;
  logic          prev_done;
  logic          mon_en;
  int            cyc;
  int            checks;
  int            passes;

  shift_add_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .done    (done),
    .product (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      passes = passes + 1;
    end
  endtask

  // One driven cycle; the reference product is queued only if the DUT will accept.
  task automatic drive(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic accept;
    exp_t e;
    @(negedge clk);
    start  = s;
    a      = av;
    b      = bv;
    accept = ready && s;
    @(posedge clk);
    #1;
    if (accept) begin
      e.prod = PW'(av) * PW'(bv);
      e.cyc  = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !ready) && n < 4 * W) begin
      drive(1'b0, W'($urandom), W'($urandom));
      n = n + 1;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    exp_q.delete();
    model_prod = '0;
    prev_done  = 1'b0;
    mon_en     = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    rst = 1'b0;
  endtask

  task automatic mul(input logic [W-1:0] av, input logic [W-1:0] bv);
    drive(1'b1, av, bv);
    drain();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      if (done) begin
        check("done_expected", 64'(exp_q.size() != 0), 64'd1);
        check("done_single_cycle", 64'(prev_done), 64'd0);
        check("ready_low_in_done", 64'(ready), 64'd0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("product", 64'(product), 64'(e.prod));
          check("latency", 64'(cyc - e.cyc), 64'(W));
          model_prod = e.prod;
        end
      end else begin
        check("product_hold", 64'(product), 64'(model_prod));
      end
      prev_done = done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks     = 0;
    passes     = 0;
    cyc        = 0;
    mon_en     = 1'b0;
    prev_done  = 1'b0;
    model_prod = '0;
    rst        = 1'b1;
    start      = 1'b0;
    a          = '0;
    b          = '0;

    do_reset(2);
    repeat (10) drive(1'b0, W'($urandom), W'($urandom));
    check("idle_ready", 64'(ready), 64'd1);

    // Directed products including corners and zero operands.
    mul(8'd13, 8'd11);
    mul(8'd15, 8'd15);
    mul(8'd0, 8'd9);
    mul(8'd9, 8'd0);
    mul(8'd1, 8'd15);
    mul(8'd255, 8'd255);
    mul(8'd200, 8'd3);

    // start held through RUN/DONE with changing operands; only IDLE accepts count.
    drive(1'b1, 8'd21, 8'd17);
    repeat (W + 2) drive(1'b1, W'($urandom), W'($urandom));
    drain();

    // Reset mid-run abandons the operation without a done pulse.
    drive(1'b1, 8'd7, 8'd6);
    drive(1'b0, 8'd0, 8'd0);
    do_reset(1);
    mul(8'd5, 8'd3);

    // Random sweep with random start gaps and occasional back-to-back start.
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, W'($urandom), W'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        drain();
      end else begin
        while (!ready) drive($urandom_range(0, 1) == 1, W'($urandom), W'($urandom));
      end
    end
    drain();
    repeat (3) drive(1'b0, 8'd0, 8'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned WIDTH x WIDTH multiplier using one WIDTH-bit ripple-carry adder built from full-adder cells.
- Computes the product by iterative shift-and-add, one multiplier bit per cycle.
- Trades the combinational partial-product array for a small accumulator datapath.
- Sits downstream of operand sources; drives product consumers through a start/ready/done handshake.

Parameters:
- WIDTH, 4, operand width in bits (legal values 2..16); product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only when ready=1.
- a  input  WIDTH  multiplicand; captured on the accepting edge.
- b  input  WIDTH  multiplier; captured on the accepting edge.
- ready  output  1  high only in IDLE.
- done  output  1  one-cycle pulse; product valid.
- product  output  2*WIDTH  registered result; held until the next completion.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, ready=1, done=0, product=0, internal regs=0.
- Reset has priority over all other activity, including mid-RUN: the operation is abandoned and no done pulse is produced.
- States:
  - IDLE: ready=1. Accept condition: start=1 at an edge. On accept: mcand<=a, mplr<=b, acc<=0, cnt<=0, go to RUN.
  - RUN: ready=0. Each cycle:
    - {c,sum} = acc + (mplr[0] ? mcand : 0), computed by the ripple adder with cin=0.
    - Then {acc,mplr} <= {c,sum,mplr} >> 1, i.e. acc<={c,sum[WIDTH-1:1]}, mplr<={sum[0],mplr[WIDTH-1:1]}.
    - cnt<=cnt+1. When cnt==WIDTH-1, load product<={next acc,next mplr} and go to DONE.
  - DONE: done=1, ready=0, for exactly one cycle; then IDLE unconditionally.
- Latency: accepting edge E. RUN covers cycles E+1..E+WIDTH. done=1 in the cycle after edge E+WIDTH. product updates on that same edge. Total WIDTH+1 cycles from accept to done.
- Throughput: one result per WIDTH+2 cycles when start is held high (the IDLE cycle is required).
- start while RUN or DONE: ignored. No queuing, no error flag.
- Operand changes on a/b after the accepting edge: no effect.
- Width rules:
  - Adder carry-out forms acc bit WIDTH-1 after the shift, so no overflow is possible.
  - Max result (2^WIDTH-1)^2 fits in 2*WIDTH bits.
  - cnt width = clog2(WIDTH), minimum 1; terminal value WIDTH-1, no wrap.
- Zero operands: normal WIDTH-cycle run, product=0, done still pulses.
- product holds its last value through IDLE and the next RUN. It changes only on the edge into DONE, or on reset.
- Illegal state encodings: go to IDLE.

Decomposition:
- Shared package (mult_pkg):
  - State encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH constant.
  - clog2 helper function for cnt width.
- Sub-module ripple_adder:
  - Parameter WIDTH; ports cin, x, y, cout, s.
  - Built as a generate chain of the existing single-bit full-adder cell.
  - Reused by later arithmetic blocks.
- Control FSM and shift registers stay in shift_add_multiplier.

Test Plan:
- Reset then idle: hold rst 2 cycles, release -> ready=1, done=0, product=0; start=0 for 10 cycles -> no change.
- WIDTH=4, a=13, b=11, start pulse -> ready low 5 cycles, done high exactly 1 cycle at accept+5, product=143, held afterwards.
- WIDTH=4 corners:
  - 15x15 -> 225.
  - 0x9 -> 0.
  - 9x0 -> 0.
  - 1x15 -> 15.
  - Each still takes 5 cycles to done.
- start asserted every cycle during RUN/DONE with changing a/b -> ignored; product = first accepted operands only; next accept occurs in the IDLE cycle after done.
- rst asserted at cycle 2 of RUN (a=7, b=6) -> next cycle IDLE, ready=1, product=0, no done pulse; new start 5x3 -> 15.
- WIDTH=8 build: 255x255 -> 65025; 200x3 -> 600; done at accept+9; random 1000-vector sweep checked against a reference model.
